// File: rtl/adaptive_threshold_ask_detector.sv
// Adaptive-threshold ASK slicer.
// Follows the peak and valley envelopes of the integrator output and slices
// each sample against a mid-point threshold with hysteresis. rx stays idle-high
// until the peak-to-valley span is large enough to trust.
module adaptive_threshold_ask_detector #(
  parameter int WIDTH       = 11,
  parameter int DECAY_SHIFT = 8,
  parameter int HYST_SHIFT  = 2,
  parameter int MIN_SPAN    = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic             rx,
  output logic             locked,
  output logic             rx_edge
);

  localparam int W1 = WIDTH + 1;

  logic [WIDTH-1:0]       peak_q, peak_d;
  logic [WIDTH-1:0]       valley_q, valley_d;
  logic [DECAY_SHIFT-1:0] decay_cnt_q, decay_cnt_d;
  logic                   rx_q, rx_d;
  logic                   locked_q, locked_d;
  logic                   rx_edge_q, rx_edge_d;

  logic          accept, tick, can_shrink;
  logic [W1-1:0] peak_x, valley_x, x_x;
  logic [W1-1:0] span, mid, hyst, up, down;

  assign i_tready = 1'b1;
  assign accept   = i_tvalid & enable & ~reset & ~clear;
  assign tick     = accept & (decay_cnt_q == {DECAY_SHIFT{1'b1}});

  // Thresholds from the registered envelope, one bit wider so nothing wraps.
  always_comb begin
    peak_x     = {1'b0, peak_q};
    valley_x   = {1'b0, valley_q};
    x_x        = {1'b0, i_tdata};
    span       = (peak_x >= valley_x) ? (peak_x - valley_x) : '0;
    mid        = valley_x + (span >> 1);
    hyst       = span >> HYST_SHIFT;
    up         = mid + hyst;
    down       = mid - hyst;
    can_shrink = peak_x > (valley_x + W1'(1));
  end

  // Envelope tracking, lock detection and slicing; clear behaves like reset.
  always_comb begin
    peak_d      = peak_q;
    valley_d    = valley_q;
    decay_cnt_d = decay_cnt_q;
    rx_d        = rx_q;
    locked_d    = (span >= W1'(MIN_SPAN));
    rx_edge_d   = 1'b0;
    if (clear) begin
      peak_d      = '0;
      valley_d    = '1;
      decay_cnt_d = '0;
      rx_d        = 1'b1;
      locked_d    = 1'b0;
    end else if (accept) begin
      decay_cnt_d = decay_cnt_q + 1'b1;
      if (i_tdata > peak_q)          peak_d = i_tdata;
      else if (tick && can_shrink)   peak_d = peak_q - 1'b1;
      if (i_tdata < valley_q)        valley_d = i_tdata;
      else if (tick && can_shrink)   valley_d = valley_q + 1'b1;
      // Losing lock releases the line to idle on the next sample.
      if (!locked_q)                 rx_d = 1'b1;
      else if (x_x > up)             rx_d = 1'b1;
      else if (x_x < down)           rx_d = 1'b0;
      rx_edge_d = (rx_d != rx_q);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_q      <= '0;
      valley_q    <= '1;
      decay_cnt_q <= '0;
      rx_q        <= 1'b1;
      locked_q    <= 1'b0;
      rx_edge_q   <= 1'b0;
    end else begin
      peak_q      <= peak_d;
      valley_q    <= valley_d;
      decay_cnt_q <= decay_cnt_d;
      rx_q        <= rx_d;
      locked_q    <= locked_d;
      rx_edge_q   <= rx_edge_d;
    end
  end

  assign rx      = rx_q;
  assign locked  = locked_q;
  assign rx_edge = rx_edge_q;

endmodule
